// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants and types for the PC/fetch block.
// Widths, the reset PC default, the fetch-state encoding and the branch-offset width.
package pc_fetch_unit_pkg;

  localparam int              PC_WIDTH         = 16;
  localparam logic [15:0]     DEFAULT_RESET_PC = 16'h0000;
  localparam int              BR_OFF_W         = 8;

  typedef enum logic [1:0] {
    ST_START   = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DELIVER = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_branch_target_calc.sv
// Relative branch target: base + (sign-extended word offset << 1), wrapping at WIDTH bits.
// Purely combinational, zero latency, no flow control.
import pc_fetch_unit_pkg::*;

module branch_target_calc #(
  parameter int WIDTH = PC_WIDTH,
  parameter int OFF_W = BR_OFF_W
) (
  input  logic [WIDTH-1:0] base,
  input  logic [OFF_W-1:0] offset,
  output logic [WIDTH-1:0] target
);

  logic [WIDTH-1:0] off_ext;
  logic [WIDTH-1:0] off_bytes;

  assign off_ext   = {{(WIDTH-OFF_W){offset[OFF_W-1]}}, offset};
  assign off_bytes = off_ext << 1;
  assign target    = base + off_bytes;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register plus req/ack instruction fetch; one instruction per >=2 cycles, 1-cycle fetch latency.
// Memory wait states hold FETCH; decode stall holds DELIVER and defers any redirect.
import pc_fetch_unit_pkg::*;

module pc_fetch_unit #(
  parameter int               WIDTH    = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                CLK,
  input  logic                Reset,
  output logic [WIDTH-1:0]    oldPC,
  input  logic [WIDTH-1:0]    nextPC,
  output logic                imem_req,
  output logic [WIDTH-1:0]    imem_addr,
  input  logic                imem_ack,
  input  logic [WIDTH-1:0]    imem_data,
  output logic [WIDTH-1:0]    instr,
  output logic                instr_valid,
  input  logic                stall,
  input  logic                jump,
  input  logic [WIDTH-1:0]    jump_target,
  input  logic                branch_taken,
  input  logic [BR_OFF_W-1:0] branch_offset,
  output logic                align_err
);

  fetch_state_t     state;
  logic [WIDTH-1:0] branch_target;

  // Branch base is the already-advanced PC held during DELIVER.
  branch_target_calc #(
    .WIDTH (WIDTH),
    .OFF_W (BR_OFF_W)
  ) u_branch_target_calc (
    .base   (oldPC),
    .offset (branch_offset),
    .target (branch_target)
  );

  assign imem_addr = oldPC;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= ST_START;
      oldPC       <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      align_err   <= 1'b0;
    end else begin
      case (state)
        ST_START: begin
          state    <= ST_FETCH;
          imem_req <= 1'b1;
        end

        ST_FETCH: begin
          if (imem_ack) begin
            instr       <= imem_data;
            instr_valid <= 1'b1;
            oldPC       <= nextPC;
            imem_req    <= 1'b0;
            state       <= ST_DELIVER;
          end
        end

        ST_DELIVER: begin
          if (!stall) begin
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= ST_FETCH;
            // Jump beats branch; odd targets are forced even and flagged.
            if (jump) begin
              oldPC <= {jump_target[WIDTH-1:1], 1'b0};
              if (jump_target[0]) begin
                align_err <= 1'b1;
              end
            end else if (branch_taken) begin
              oldPC <= branch_target;
            end
          end
        end

        default: begin
          state       <= ST_START;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: stimulus pushes expected deliveries, a negedge monitor checks them.
module tb_pc_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [15:0] oldPC;
  logic [15:0] nextPC;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        jump;
  logic [15:0] jump_target;
  logic        branch_taken;
  logic [7:0]  branch_offset;
  logic        align_err;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
  } deliv_t;

  deliv_t sb[$];
  int     vectors     = 0;
  int     miscompares = 0;

  always #5 CLK = ~CLK;

  // External Addby2
  assign nextPC = oldPC + 16'd2;

  pc_fetch_unit #(
    .WIDTH    (16),
    .RESET_PC (16'h0000)
  ) dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .oldPC         (oldPC),
    .nextPC        (nextPC),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_data     (imem_data),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .stall         (stall),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .align_err     (align_err)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("req_timeout", {15'd0, imem_req}, 16'h0001);
  endtask

  // One fetch at exp_addr with 'waits' cycles of ack held low.
  task automatic fetch_one(input logic [15:0] exp_addr, input logic [15:0] data, input int waits);
    deliv_t e;
    wait_req();
    check("fetch_addr", imem_addr, exp_addr);
    for (int i = 0; i < waits; i++) begin
      imem_ack = 1'b0;
      tick();
      check("wait_req_held", {15'd0, imem_req}, 16'h0001);
      check("wait_pc_held", oldPC, exp_addr);
      check("wait_no_valid", {15'd0, instr_valid}, 16'h0000);
    end
    imem_ack  = 1'b1;
    imem_data = data;
    e.instr   = data;
    e.pc      = exp_addr + 16'd2;
    sb.push_back(e);
    tick();
    imem_ack  = 1'b0;
    imem_data = 16'hxxxx;
    check("req_drop_after_ack", {15'd0, imem_req}, 16'h0000);
  endtask

  task automatic deliver(input int stall_cycles, input logic j, input logic [15:0] jt,
                         input logic br, input logic [7:0] off,
                         input logic [15:0] exp_pc, input logic exp_align);
    logic [15:0] held_pc;
    logic [15:0] held_instr;
    held_pc    = oldPC;
    held_instr = instr;
    stall         = 1'b1;
    jump          = j;
    jump_target   = jt ^ 16'h0100;
    branch_taken  = 1'b1;
    branch_offset = 8'h10;
    for (int i = 0; i < stall_cycles; i++) begin
      tick();
      check("stall_valid_held", {15'd0, instr_valid}, 16'h0001);
      check("stall_pc_held", oldPC, held_pc);
      check("stall_instr_held", instr, held_instr);
    end
    stall         = 1'b0;
    jump          = j;
    jump_target   = jt;
    branch_taken  = br;
    branch_offset = off;
    tick();
    jump          = 1'b0;
    branch_taken  = 1'b0;
    check("consume_valid_drop", {15'd0, instr_valid}, 16'h0000);
    check("redirect_pc", oldPC, exp_pc);
    check("align_err", {15'd0, align_err}, {15'd0, exp_align});
    check("refetch_req", {15'd0, imem_req}, 16'h0001);
  endtask

  // Monitor: every new instruction presentation must match the scoreboard head.
  initial begin
    logic   prev;
    deliv_t e;
    prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (instr_valid === 1'b1 && prev !== 1'b1) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_valid: got instr %h with empty scoreboard", instr);
        end else begin
          e = sb.pop_front();
          check("deliver_instr", instr, e.instr);
          check("deliver_pc", oldPC, e.pc);
        end
      end
      prev = instr_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset         = 1'b1;
    imem_ack      = 1'b0;
    imem_data     = 16'h0000;
    stall         = 1'b0;
    jump          = 1'b0;
    jump_target   = 16'h0000;
    branch_taken  = 1'b0;
    branch_offset = 8'h00;
    tick();
    tick();
    check("rst_pc", oldPC, 16'h0000);
    check("rst_valid", {15'd0, instr_valid}, 16'h0000);
    check("rst_req", {15'd0, imem_req}, 16'h0000);
    check("rst_instr", instr, 16'h0000);
    check("rst_align", {15'd0, align_err}, 16'h0000);
    Reset = 1'b0;
    tick();
    check("start_to_fetch_req", {15'd0, imem_req}, 16'h0001);

    // 1: zero-wait fetch
    fetch_one(16'h0000, 16'h1234, 0);
    deliver(0, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h0002, 1'b0);
    // 2: three wait states, then jump to set up a branch at 0x0010
    fetch_one(16'h0002, 16'h5678, 3);
    deliver(0, 1'b1, 16'h000E, 1'b0, 8'h00, 16'h0004 + 16'h000A, 1'b0);
    // 3: stalled branch, applied only when stall drops
    fetch_one(16'h000E, 16'h9ABC, 0);
    deliver(4, 1'b0, 16'h0000, 1'b1, 8'hFC, 16'h0008, 1'b0);
    // 4: jump with odd target beats branch
    fetch_one(16'h0008, 16'h1111, 0);
    deliver(0, 1'b1, 16'hAAAF, 1'b1, 8'h05, 16'hAAAE, 1'b1);
    fetch_one(16'hAAAE, 16'h2222, 0);
    deliver(0, 1'b1, 16'hFFFE, 1'b0, 8'h00, 16'hFFFE, 1'b1);
    // 5: sequential wrap and negative branch wrap
    fetch_one(16'hFFFE, 16'h3333, 0);
    deliver(0, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1);
    fetch_one(16'h0000, 16'h4444, 0);
    deliver(0, 1'b0, 16'h0000, 1'b1, 8'h80, 16'hFF02, 1'b1);
    // 6: reset mid-fetch with a coincident ack
    wait_req();
    check("pre_reset_addr", imem_addr, 16'hFF02);
    Reset     = 1'b1;
    imem_ack  = 1'b1;
    imem_data = 16'hDEAD;
    tick();
    imem_ack  = 1'b0;
    Reset     = 1'b0;
    check("midrst_valid", {15'd0, instr_valid}, 16'h0000);
    check("midrst_pc", oldPC, 16'h0000);
    check("midrst_align", {15'd0, align_err}, 16'h0000);
    check("midrst_req_start", {15'd0, imem_req}, 16'h0000);
    check("midrst_instr", instr, 16'h0000);
    tick();
    check("midrst_refetch_req", {15'd0, imem_req}, 16'h0001);
    fetch_one(16'h0000, 16'h5555, 0);
    deliver(0, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h0002, 1'b0);

    tick();
    tick();
    check("scoreboard_drained", 16'(sb.size()), 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
